// File: rtl/tt_capture_pkg.sv
// Shared types and constants for the truth-table capture block.
// Optional compare feature is enabled with TT_CAPTURE_COMPARE_EN.
package tt_capture_pkg;

    localparam int NUM_ROWS = 8;
    localparam int CODE_W   = 8;
    localparam int ROW_W    = 3;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [CODE_W-1:0] shift_in(
        input logic [CODE_W-1:0] sr,
        input logic              bit_in
    );
        return {sr[CODE_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Per-row settle countdown: load a cycle count, count down, flag expiry.
// expire is high on the last settle cycle of a row.
module tt_settle_timer
    import tt_capture_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             count,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] remain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain <= '0;
        end else if (load) begin
            remain <= value;
        end else if (count && remain != '0) begin
            remain <= remain - 1'b1;
        end
    end

    assign expire = (remain <= CNT_W'(1));

endmodule

// File: rtl/truth_table_capture.sv
// Walks all 8 input rows of a 3-input function and captures its truth table.
// Compare port pair (expected/match) exists only with TT_CAPTURE_COMPARE_EN.
module truth_table_capture
    import tt_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              drive_in1,
    output logic              drive_in2,
    output logic              drive_in3,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
`ifdef TT_CAPTURE_COMPARE_EN
    input  logic [CODE_W-1:0] expected,
    output logic              match,
`endif
    output logic [CODE_W-1:0] table_code
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam bit               SKIP      = (SETTLE_CYCLES == 0);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);

    state_t             state;
    logic [ROW_W-1:0]   row;
    logic [ROW_W-1:0]   drive;
    logic [CODE_W-1:0]  shreg;
    logic               timer_load;
    logic               timer_count;
    logic               expire;

    assign timer_load  = (state == IDLE && start)
                       || (state == SAMPLE && row != LAST_ROW);
    assign timer_count = (state == SETTLE);

    tt_settle_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .count  (timer_count),
        .value  (SETTLE_LD),
        .expire (expire)
    );

    assign {drive_in1, drive_in2, drive_in3} = drive;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            drive      <= '0;
            shreg      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_code <= '0;
`ifdef TT_CAPTURE_COMPARE_EN
            match      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        row   <= '0;
                        drive <= '0;
                        shreg <= '0;
                        busy  <= 1'b1;
                        state <= SKIP ? SAMPLE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (expire) state <= SAMPLE;
                end
                SAMPLE: begin
                    shreg <= shift_in(shreg, dut_out);
                    if (row == LAST_ROW) begin
                        drive <= '0;
                        state <= DONE;
                    end else begin
                        row   <= row + 1'b1;
                        drive <= row + 1'b1;
                        state <= SKIP ? SAMPLE : SETTLE;
                    end
                end
                DONE: begin
                    table_code <= shreg;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
`ifdef TT_CAPTURE_COMPARE_EN
                    match      <= (shreg == expected);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: two instances (settle 2 and settle 0)
// each driving a tb-side 3-input function model.
module tb_truth_table_capture;

    localparam int S_SLOW = 2;
    localparam int S_FAST = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_s = 1'b0;
    logic       start_f = 1'b0;
    logic [7:0] func_s = 8'h00;
    logic [7:0] func_f = 8'h00;

    logic       a_s, b_s, c_s, out_s, busy_s, done_s;
    logic       a_f, b_f, c_f, out_f, busy_f, done_f;
    logic [7:0] code_s, code_f;
`ifdef TT_CAPTURE_COMPARE_EN
    logic [7:0] exp_s = 8'h00;
    logic [7:0] exp_f = 8'h00;
    logic       match_s, match_f;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign out_s = func_s[{a_s, b_s, c_s}];
    assign out_f = func_f[{a_f, b_f, c_f}];

    truth_table_capture #(.SETTLE_CYCLES(S_SLOW)) u_slow (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s),
        .drive_in1  (a_s),
        .drive_in2  (b_s),
        .drive_in3  (c_s),
        .dut_out    (out_s),
        .busy       (busy_s),
        .done       (done_s),
`ifdef TT_CAPTURE_COMPARE_EN
        .expected   (exp_s),
        .match      (match_s),
`endif
        .table_code (code_s)
    );

    truth_table_capture #(.SETTLE_CYCLES(S_FAST)) u_fast (
        .clk        (clk),
        .rst        (rst),
        .start      (start_f),
        .drive_in1  (a_f),
        .drive_in2  (b_f),
        .drive_in3  (c_f),
        .dut_out    (out_f),
        .busy       (busy_f),
        .done       (done_f),
`ifdef TT_CAPTURE_COMPARE_EN
        .expected   (exp_f),
        .match      (match_f),
`endif
        .table_code (code_f)
    );

    // Row r of the function lands at code bit 7-r.
    function automatic logic [7:0] ref_code(input logic [7:0] f);
        logic [7:0] c;
        c = 8'h00;
        for (int r = 0; r < 8; r++) c[7-r] = f[r];
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full scan on the slow (sel=0) or fast (sel=1) instance.
    task automatic scan(input bit sel, input logic [7:0] f,
                        input bit poke, output logic [7:0] got);
        int hold, lat, n;
        bit seen;
        logic [7:0] want;
        hold = (sel ? S_FAST : S_SLOW) + 1;
        lat  = 8 * hold + 1;
        want = ref_code(f);
        if (sel) func_f = f; else func_s = f;
        if (sel) start_f = 1'b1; else start_s = 1'b1;
        tick();
        start_f = 1'b0;
        start_s = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n <= lat + 10) begin
            if (sel ? done_f : done_s) begin
                seen = 1'b1;
            end else begin
                check(sel ? "drive_f" : "drive_s",
                      32'(sel ? {a_f, b_f, c_f} : {a_s, b_s, c_s}),
                      32'((n < 8 * hold) ? n / hold : 0));
                check(sel ? "busy_f" : "busy_s",
                      32'(sel ? busy_f : busy_s), 32'(n < lat));
                start_s = (!sel && poke && (n == 5 || n == 10));
                tick();
                n++;
            end
        end
        check(sel ? "latency_f" : "latency_s", 32'(n), 32'(lat));
        got = sel ? code_f : code_s;
        check(sel ? "code_f" : "code_s", 32'(got), 32'(want));
        check(sel ? "busy_done_f" : "busy_done_s",
              32'(sel ? busy_f : busy_s), 32'd0);
        tick();
        check(sel ? "done_width_f" : "done_width_s",
              32'(sel ? done_f : done_s), 32'd0);
        check(sel ? "code_hold_f" : "code_hold_s",
              32'(sel ? code_f : code_s), 32'(want));
    endtask

    initial begin : main
        logic [7:0] got_s, got_f, f;
        int dones;

        repeat (3) tick();
        check("rst_code", 32'(code_s), 32'h00);
        check("rst_busy", 32'(busy_s), 32'd0);
        check("rst_done", 32'(done_s), 32'd0);
        check("rst_drive", 32'({a_s, b_s, c_s}), 32'd0);
        rst = 1'b0;
        tick();

        // Rows 000, 011, 110 high.
        scan(1'b0, 8'h49, 1'b0, got_s);
        check("code_0x92", 32'(got_s), 32'h92);

        scan(1'b0, 8'h00, 1'b0, got_s);
        check("tied0", 32'(got_s), 32'h00);
        scan(1'b0, 8'hFF, 1'b0, got_s);
        check("tied1", 32'(got_s), 32'hFF);

        // start re-pulsed mid-scan must be ignored.
        scan(1'b0, 8'h49, 1'b1, got_s);
        repeat (30) begin
            check("no_restart", 32'(done_s), 32'd0);
            tick();
        end

        // Reset mid-scan.
        func_s = 8'hA5;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        repeat (12) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy_s), 32'd0);
        check("mid_rst_done", 32'(done_s), 32'd0);
        check("mid_rst_code", 32'(code_s), 32'h00);
        check("mid_rst_drive", 32'({a_s, b_s, c_s}), 32'd0);
        tick();
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            tick();
            if (done_s) dones++;
        end
        check("no_done_after_rst", 32'(dones), 32'd0);
        check("code_after_rst", 32'(code_s), 32'h00);
        scan(1'b0, 8'h5A, 1'b0, got_s);

        for (int i = 0; i < 4; i++) begin
            f = 8'($urandom);
            scan(1'b0, f, 1'b0, got_s);
        end

        scan(1'b1, 8'h49, 1'b0, got_f);
        check("fast_vs_slow", 32'(got_f), 32'h92);
        for (int i = 0; i < 4; i++) begin
            f = 8'($urandom);
            scan(1'b1, f, 1'b0, got_f);
        end

`ifdef TT_CAPTURE_COMPARE_EN
        exp_s = 8'h92;
        scan(1'b0, 8'h49, 1'b0, got_s);
        check("match_hit", 32'(match_s), 32'd1);
        exp_s = 8'h93;
        scan(1'b0, 8'h49, 1'b0, got_s);
        check("match_miss", 32'(match_s), 32'd0);
        check("match_miss_code", 32'(code_s), 32'h92);
        for (int i = 0; i < 3; i++) begin
            f = 8'($urandom);
            exp_f = ($urandom_range(0, 1) == 1) ? ref_code(f) : 8'($urandom);
            scan(1'b1, f, 1'b0, got_f);
            check("match_rand", 32'(match_f),
                  32'(ref_code(f) == exp_f));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/truth_table_capture.md
TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: wait cycles per row before sampling; legal range 0..255.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  scan request; sampled only in IDLE.
REQ-005 SHALL have port drive_in1 / drive_in2 / drive_in3  output  1 each  stimulus applied to the 3-input function under test.
REQ-006 SHALL have port dut_out  input  1  response of the function under test.
REQ-007 SHALL have port busy  output  1  high while a scan is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when table_code becomes valid.
REQ-009 SHALL have port table_code  output  8  captured truth-table code.
REQ-010 SHALL have port expected  input  8  reference code; present only with the compare feature (REQ-027).
REQ-011 SHALL have port match  output  1  compare result; present only with the compare feature (REQ-027).

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-013 SHALL go IDLE->SETTLE on start=1, loading row index 0 and clearing the shift register.
REQ-014 SHALL drive {drive_in1,drive_in2,drive_in3} = row index (3 bits, in1 = MSB) in SETTLE and SAMPLE.
REQ-015 SHALL hold each row for SETTLE_CYCLES cycles in SETTLE, then one cycle in SAMPLE; with SETTLE_CYCLES=0, SETTLE is skipped.
REQ-016 SHALL, in SAMPLE, shift dut_out into the LSB of the 8-bit shift register (shift-left), so row 000 ends at bit 7 and row 111 at bit 0.
REQ-017 SHALL, in SAMPLE, increment the row index if it is below 7 and return to SETTLE; at row 7, SHALL enter DONE.
REQ-018 SHALL, in DONE, copy the shift register to table_code, pulse done for exactly one cycle and return to IDLE.
REQ-019 SHALL make the latency from the start-accept edge to done high exactly 8*(SETTLE_CYCLES+1)+1 cycles.
REQ-020 SHALL hold busy high from the cycle after start is accepted through the DONE cycle; busy is low in IDLE.
REQ-021 SHALL ignore start while busy, with no restart and no queuing.
REQ-022 SHALL hold table_code stable from done until the next done; a new scan does not clear it early.
REQ-023 SHALL drive the drive_* outputs to 000 in IDLE and DONE.
REQ-024 SHALL size the row counter to 3 bits and the settle counter to 8 bits, with no wrap-around beyond row 7.

Reset
REQ-025 SHALL, on rst=1, immediately force: state IDLE, drive_* = 000, busy 0, done 0, table_code 0x00, shift register 0, counters 0, and match 0 when present.
REQ-026 SHALL abort a scan on reset mid-scan, with no done pulse and table_code = 0x00; the first start after rst deasserts begins a fresh scan.

Configuration
REQ-027 SHALL compile in the compare feature only when macro TT_CAPTURE_COMPARE_EN is defined.
REQ-028 SHALL, with TT_CAPTURE_COMPARE_EN defined, register match = (shift register == expected) in the DONE cycle, so it updates with table_code and holds until the next done.
REQ-029 SHALL, without TT_CAPTURE_COMPARE_EN, omit the expected and match ports and all compare logic.

Structure
REQ-030 SHALL take the FSM state enum and the constants NUM_ROWS=8 and CODE_W=8 from shared package tt_capture_pkg.
REQ-031 SHALL place the settle countdown in sub-module tt_settle_timer (load, count, expire), instantiated once.

Verification
REQ-032 SHALL check: SETTLE_CYCLES=2, DUT modelling rows 000/011/110 = 1 and all others 0 -> table_code=0x92, done exactly 25 cycles after start accepted.
REQ-033 SHALL check: dut_out tied 0, then tied 1 -> table_code 0x00, then 0xFF; done pulse width 1 cycle each.
REQ-034 SHALL check: start re-asserted at cycles 5 and 10 of a scan -> single done at cycle 25; drive_* still sequence 000..111 in order.
REQ-035 SHALL check: rst pulsed at cycle 12 of a scan -> outputs at reset values same cycle, no done; the next scan yields the correct code.
REQ-036 SHALL check: with TT_CAPTURE_COMPARE_EN, expected=0x92 -> match=1; expected=0x93 -> match=0, table_code still 0x92.
REQ-037 SHALL check: SETTLE_CYCLES=0 -> each row lasts 1 cycle, done 9 cycles after start, code identical to the SETTLE_CYCLES=2 result.
